multi_byte_serial_add_sub: RTL and testbench

MULTI_BYTE_SERIAL_ADD_SUB -- requirements
Module: multi_byte_serial_add_sub

---
 rtl/multi_byte_serial_add_sub.sv | 143 ++++++++++++++
 tb/tb_multi_byte_serial_add_sub.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/multi_byte_serial_add_sub.sv
// rtl/multi_byte_serial_add_sub.sv - byte-serial adder/subtractor with ready/valid handshake
module multi_byte_serial_add_sub #(
    parameter int NBYTES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] A,
    input  logic [8*NBYTES-1:0] B,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] result,
    output logic                carry_out,
    output logic                zero,
    output logic                negative,
    output logic                overflow
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic           sub_reg;
    logic [IW-1:0]  idx;
    logic           carry;
    logic [W-1:0]   result_reg;
    logic           carry_out_reg;
    logic           overflow_reg;

    logic           accept;
    logic           last_byte;
    logic [IW+2:0]  byte_shift;
    logic [W-1:0]   a_shifted;
    logic [W-1:0]   b_shifted;
    logic [7:0]     a_byte;
    logic [7:0]     b_byte;
    logic [8:0]     byte_sum;
    logic [7:0]     low7_sum;
    logic [W-1:0]   byte_mask;
    logic [W-1:0]   byte_insert;

    assign accept    = in_valid && (state == IDLE);
    assign last_byte = (idx == IW'(NBYTES - 1));

    // Select the current byte lane and form its 8-bit sum; B is inverted for subtraction
    always_comb begin
        byte_shift  = {idx, 3'b000};
        a_shifted   = a_reg >> byte_shift;
        b_shifted   = b_reg >> byte_shift;
        a_byte      = a_shifted[7:0];
        b_byte      = b_shifted[7:0] ^ {8{sub_reg}};
        byte_sum    = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, carry};
        // bit 7 of the low-7-bit sum is the carry into the byte's sign bit
        low7_sum    = {1'b0, a_byte[6:0]} + {1'b0, b_byte[6:0]} + {7'b0, carry};
        byte_mask   = W'(8'hFF) << byte_shift;
        byte_insert = W'(byte_sum[7:0]) << byte_shift;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_byte) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture on acceptance, then one byte per cycle into the result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg         <= '0;
            b_reg         <= '0;
            sub_reg       <= 1'b0;
            idx           <= '0;
            carry         <= 1'b0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else if (accept) begin
            a_reg   <= A;
            b_reg   <= B;
            sub_reg <= sub;
            idx     <= '0;
            carry   <= sub;
        end else if (state == RUN) begin
            result_reg <= (result_reg & ~byte_mask) | byte_insert;
            carry      <= byte_sum[8];
            idx        <= idx + 1'b1;
            if (last_byte) begin
                carry_out_reg <= byte_sum[8];
                overflow_reg  <= low7_sum[7] ^ byte_sum[8];
            end
        end
    end

    assign result    = result_reg;
    assign carry_out = carry_out_reg;
    assign overflow  = overflow_reg;
    assign zero      = (result_reg == '0);
    assign negative  = result_reg[W-1];

endmodule

// File: tb/tb_multi_byte_serial_add_sub.sv
// tb/tb_multi_byte_serial_add_sub.sv - directed scoreboard bench for the serial add/sub block
module tb_multi_byte_serial_add_sub;

    localparam int NBYTES = 2;
    localparam int W      = 8 * NBYTES;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         zero;
    logic         negative;
    logic         overflow;

    typedef struct {
        logic [W-1:0] res;
        logic         cy;
        logic         z;
        logic         n;
        logic         v;
    } exp_t;

    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    multi_byte_serial_add_sub #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        logic [W:0] full;
        if (s) full = {1'b0, a} - {1'b0, b};
        else   full = {1'b0, a} + {1'b0, b};
        e.res = full[W-1:0];
        // for subtraction the carry flag means "no borrow"
        e.cy  = s ? (a >= b) : full[W];
        e.z   = (e.res == '0);
        e.n   = e.res[W-1];
        if (s) e.v = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
        else   e.v = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int hold);
        int   cyc;
        exp_t e;
        logic [W-1:0] held_res;
        logic [3:0]   held_flags;
        @(negedge clk);
        A        = a;
        B        = b;
        sub      = s;
        in_valid = 1'b1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        exp_q.push_back(model(a, b, s));
        @(posedge clk);
        #1;
        // keep requesting with different operands while busy: must be ignored
        A   = W'($urandom);
        B   = W'($urandom);
        sub = ~s;
        check("in_ready_busy", 32'(in_ready), 32'd0);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        check("latency", 32'(cyc), 32'(NBYTES));
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("result", 32'(result), 32'(e.res));
            check("carry_out", 32'(carry_out), 32'(e.cy));
            check("zero", 32'(zero), 32'(e.z));
            check("negative", 32'(negative), 32'(e.n));
            check("overflow", 32'(overflow), 32'(e.v));
        end
        held_res   = result;
        held_flags = {carry_out, zero, negative, overflow};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_result", 32'(result), 32'(held_res));
            check("bp_flags", 32'({carry_out, zero, negative, overflow}), 32'(held_flags));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        sub       = 1'b0;
        out_ready = 1'b0;
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_negative", 32'(negative), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        #6;
        rst_n = 1'b1;

        run_op(16'h00FF, 16'h0001, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(16'h1234, 16'h1234, 1'b1, 0);
        run_op(16'h0000, 16'h0001, 1'b1, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 0);
        run_op(16'hA5C3, 16'h5A7E, 1'b0, 5);
        for (int i = 0; i < 6; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 0);
        end

        // reset in the middle of an operation, after byte 0 has been processed
        @(negedge clk);
        A        = 16'h1111;
        B        = 16'h2222;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_no_valid", 32'(out_valid), 32'd0);
        end
        run_op(16'h0003, 16'h0004, 1'b0, 0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
